mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Sequencer for the HI/LO-producing multiply/divide resources in the EX stage.
- Accepts one MDU operation per EX-stage instruction and drives the iterative radix-2 divider through its opn_valid/res_ready/res_valid handshake.
- Produces the pipeline stall request, handles flushes and divide-by-zero, and emits one HI/LO write per committed operation.
- Multiplier is combinational and external; its 64-bit product arrives on mul_result.

Parameters:
- DIV_TIMEOUT, 40, maximum BUSY cycles allowed before the divider is declared hung.
- CNT_W, 6, width of the BUSY cycle counter; must satisfy 2^CNT_W > DIV_TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- op_valid  in  1  EX stage holds an MDU instruction.
- op_code  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved, treated as no-op.
- num1  in  32  rs operand.
- num2  in  32  rt operand.
- hi_in  in  32  current HI (bypassed).
- lo_in  in  32  current LO (bypassed).
- flush  in  1  EX-stage flush.
- stall_next  in  1  E->M register stalled; commit not allowed this cycle.
- mul_result  in  64  product from the external multiplier for num1/num2.
- div_opn_valid  out  1  operands valid to divider.
- div_sign  out  1  1 = signed divide.
- div_a  out  32  registered dividend.
- div_b  out  32  registered divisor.
- div_res_ready  out  1  controller can accept the quotient/remainder.
- div_abort  out  1  one-cycle pulse that resets the divider.
- div_res_valid  in  1  divider result valid.
- div_result  in  64  {remainder, quotient}.
- stall_req  out  1  hold IF/ID/EX.
- hilo_we  out  1  HI/LO write strobe.
- hilo_wdata  out  64  {HI, LO} value to write.
- busy  out  1  FSM not IDLE.
- div_err  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state IDLE; counter 0; div_err 0; div_a, div_b, div_sign and result register cleared.
  - All outputs are 0 while in IDLE with op_valid=0.
- States are IDLE, BUSY and DONE. busy = (state != IDLE).
- IDLE, MULT/MULTU/MTHI/MTLO (single-cycle path):
  - hilo_wdata: mul_result for MULT/MULTU; {num1, lo_in} for MTHI; {hi_in, num1} for MTLO.
  - hilo_we = op_valid & ~flush & ~stall_next, combinational and in the same cycle.
  - stall_req stays 0.
- IDLE, DIV/DIVU with num2 != 0:
  - stall_req = 1 combinationally in that cycle.
  - Latch num1, num2 and sign (1 only for DIV).
  - Next state BUSY, counter cleared.
- IDLE, DIV/DIVU with num2 == 0:
  - Divider is not issued.
  - hilo_wdata = {num1, 32'hFFFF_FFFF}, written under the same hilo_we rule as MULT.
  - stall_req stays 0.
- BUSY:
  - div_opn_valid = 1, div_res_ready = 1, stall_req = 1; counter increments each cycle.
  - On div_res_valid: capture div_result into the result register and go to DONE.
  - When the counter reaches DIV_TIMEOUT with no res_valid: pulse div_abort, set div_err (sticky until rst), load result 64'h0, go to DONE.
- DONE:
  - stall_req = 0; hilo_wdata = result register; hilo_we = ~stall_next & ~flush.
  - If stall_next = 1, hold DONE with the result unchanged; the same instruction stays in EX and the divider is not reissued.
  - The cycle hilo_we fires, go to IDLE.
- Flush in BUSY or DONE:
  - Next state IDLE; div_abort pulses 1 cycle if in BUSY; no hilo_we.
  - A flush in IDLE suppresses hilo_we and any new issue.
- rst mid-operation: IDLE next cycle, no write, div_abort not required because the divider shares rst.
- The MTHI/MTLO/MULT cases write at most once per instruction.

Test Plan:
- MULTU, num1=3, num2=5, mul_result=64'd15, stall_next=0 -> hilo_we=1 same cycle, hilo_wdata=64'd15, stall_req=0.
- DIV, num1=-7, num2=2; divider returns {32'hFFFF_FFFF, 32'hFFFF_FFFD} after 34 cycles -> stall_req high from issue until DONE; exactly one hilo_we with that value; div_sign=1.
- DIVU completes while stall_next=1 for 3 cycles -> stays DONE, hilo_we=0 for 3 cycles, then a single write of the held result, state IDLE.
- DIV issued, flush asserted on the 10th BUSY cycle -> div_abort 1-cycle pulse, state IDLE next cycle, no hilo_we, stall_req=0.
- DIVU with num2=0, num1=32'h1234 -> no div_opn_valid, hilo_wdata={32'h1234, 32'hFFFF_FFFF}, hilo_we=1 same cycle.
- Divider never raises res_valid, DIV_TIMEOUT=40 -> at cycle 40 div_abort pulses, div_err=1 (held until rst), hilo_wdata=0 written once.

Source files
------------

// File: rtl/mdu_ctrl.sv
// MDU sequencer: single-cycle HI/LO writes for MULT/MTHI/MTLO and divide-by-zero; iterative divide via BUSY/DONE FSM.
// Divide holds stall_req from issue until DONE; commit waits out stall_next, flush aborts at any stage.
module mdu_ctrl #(
    parameter int DIV_TIMEOUT = 40,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic        flush,
    input  logic        stall_next,
    input  logic [63:0] mul_result,
    output logic        div_opn_valid,
    output logic        div_sign,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_res_ready,
    output logic        div_abort,
    input  logic        div_res_valid,
    input  logic [63:0] div_result,
    output logic        stall_req,
    output logic        hilo_we,
    output logic [63:0] hilo_wdata,
    output logic        busy,
    output logic        div_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    // Timeout fires on the DIV_TIMEOUT-th BUSY cycle, i.e. as the counter would reach DIV_TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

    state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [63:0] res_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        sign_q;
    logic        err_q;

    logic is_mul, is_mt, is_div, div_by_zero, idle_act, issue, idle_wr, timeout, busy_exit;

    always_comb begin
        is_mul      = (op_code == OP_MULT) || (op_code == OP_MULTU);
        is_mt       = (op_code == OP_MTHI) || (op_code == OP_MTLO);
        is_div      = (op_code == OP_DIV) || (op_code == OP_DIVU);
        div_by_zero = (num2 == 32'd0);
        idle_act    = (state == IDLE) && op_valid && !flush;
        issue       = idle_act && is_div && !div_by_zero;
        idle_wr     = idle_act && !stall_next && (is_mul || is_mt || (is_div && div_by_zero));
        timeout     = (state == BUSY) && !div_res_valid && (cnt == CNT_LAST);
        busy_exit   = flush || div_res_valid || timeout;
    end

    always_comb begin
        stall_req  = 1'b0;
        hilo_we    = 1'b0;
        hilo_wdata = 64'd0;
        div_abort  = 1'b0;
        case (state)
            IDLE: begin
                stall_req = issue;
                hilo_we   = idle_wr;
                if (op_valid) begin
                    case (op_code)
                        OP_MULT, OP_MULTU: hilo_wdata = mul_result;
                        OP_MTHI:           hilo_wdata = {num1, lo_in};
                        OP_MTLO:           hilo_wdata = {hi_in, num1};
                        OP_DIV, OP_DIVU:   if (div_by_zero) hilo_wdata = {num1, 32'hFFFF_FFFF};
                        default:           hilo_wdata = 64'd0;
                    endcase
                end
            end
            BUSY: begin
                stall_req = 1'b1;
                div_abort = flush || timeout;
            end
            DONE: begin
                hilo_wdata = res_q;
                hilo_we    = !stall_next && !flush;
            end
            default: ;
        endcase
    end

    assign div_opn_valid = (state == BUSY);
    assign div_res_ready = (state == BUSY);
    assign busy          = (state != IDLE);
    assign div_err       = err_q;
    assign div_a         = a_q;
    assign div_b         = b_q;
    assign div_sign      = sign_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            res_q  <= 64'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            sign_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state  <= BUSY;
                        cnt    <= '0;
                        a_q    <= num1;
                        b_q    <= num2;
                        sign_q <= (op_code == OP_DIV);
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (busy_exit) begin
                        a_q    <= 32'd0;
                        b_q    <= 32'd0;
                        sign_q <= 1'b0;
                    end
                    // Flush beats a same-cycle result; a real result beats the timeout.
                    if (flush) begin
                        state <= IDLE;
                    end else if (div_res_valid) begin
                        res_q <= div_result;
                        state <= DONE;
                    end else if (timeout) begin
                        res_q <= 64'd0;
                        err_q <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (flush || !stall_next) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl; expected HI/LO writes go through a scoreboard queue.
module tb_mdu_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = 3'd0;
    logic [31:0] num1 = 32'd0;
    logic [31:0] num2 = 32'd0;
    logic [31:0] hi_in = 32'd0;
    logic [31:0] lo_in = 32'd0;
    logic        flush = 1'b0;
    logic        stall_next = 1'b0;
    logic [63:0] mul_result = 64'd0;
    logic        div_res_valid = 1'b0;
    logic [63:0] div_result = 64'd0;
    logic        div_opn_valid, div_sign, div_res_ready, div_abort;
    logic [31:0] div_a, div_b;
    logic        stall_req, hilo_we, busy, div_err;
    logic [63:0] hilo_wdata;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    mdu_ctrl #(.DIV_TIMEOUT(40), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
        .num1(num1), .num2(num2), .hi_in(hi_in), .lo_in(lo_in),
        .flush(flush), .stall_next(stall_next), .mul_result(mul_result),
        .div_opn_valid(div_opn_valid), .div_sign(div_sign), .div_a(div_a), .div_b(div_b),
        .div_res_ready(div_res_ready), .div_abort(div_abort),
        .div_res_valid(div_res_valid), .div_result(div_result),
        .stall_req(stall_req), .hilo_we(hilo_we), .hilo_wdata(hilo_wdata),
        .busy(busy), .div_err(div_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Every observed write must match the oldest expected one.
    always @(negedge clk) begin
        if (hilo_we === 1'b1) begin
            chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("hilo_wdata", hilo_wdata, exp_q.pop_front());
        end
    end

    initial begin
        // Reset
        cyc(); cyc();
        rst = 1'b0;
        neg();
        chk("rst_stall_req", stall_req, 0);
        chk("rst_hilo_we", hilo_we, 0);
        chk("rst_hilo_wdata", hilo_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_div_err", div_err, 0);
        chk("rst_opn_valid", div_opn_valid, 0);
        chk("rst_abort", div_abort, 0);
        chk("rst_div_a", div_a, 0);

        // MULTU single cycle
        cyc();
        op_valid = 1'b1; op_code = 3'd1; num1 = 32'd3; num2 = 32'd5; mul_result = 64'd15;
        exp_q.push_back(64'd15);
        neg();
        chk("multu_we", hilo_we, 1);
        chk("multu_stall", stall_req, 0);
        cyc();

        // MTHI
        op_code = 3'd4; num1 = 32'hAAAA_0001; lo_in = 32'h5555_0002; hi_in = 32'h1111_2222;
        exp_q.push_back({32'hAAAA_0001, 32'h5555_0002});
        neg();
        chk("mthi_we", hilo_we, 1);
        cyc();

        // MTLO held one cycle by stall_next, then written once
        op_code = 3'd5; num1 = 32'hCAFE_BABE; stall_next = 1'b1;
        neg();
        chk("mtlo_stalled_we", hilo_we, 0);
        cyc();
        stall_next = 1'b0;
        exp_q.push_back({32'h1111_2222, 32'hCAFE_BABE});
        neg();
        chk("mtlo_we", hilo_we, 1);
        cyc();

        // Flush in IDLE suppresses the write
        op_code = 3'd0; mul_result = 64'hDEAD; flush = 1'b1;
        neg();
        chk("idle_flush_we", hilo_we, 0);
        cyc();
        flush = 1'b0; op_valid = 1'b0;

        // DIV -7 / 2, result after 34 BUSY cycles
        cyc();
        op_valid = 1'b1; op_code = 3'd2; num1 = 32'hFFFF_FFF9; num2 = 32'd2;
        neg();
        chk("div_issue_stall", stall_req, 1);
        chk("div_issue_we", hilo_we, 0);
        cyc();
        neg();
        chk("div_sign", div_sign, 1);
        chk("div_a", div_a, 64'hFFFF_FFF9);
        chk("div_b", div_b, 64'd2);
        chk("div_opn_valid", div_opn_valid, 1);
        chk("div_res_ready", div_res_ready, 1);
        chk("div_busy", busy, 1);
        repeat (33) cyc();
        div_res_valid = 1'b1; div_result = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
        exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
        neg();
        chk("div_busy34_stall", stall_req, 1);
        chk("div_busy34_abort", div_abort, 0);
        cyc();
        div_res_valid = 1'b0;
        neg();
        chk("div_done_stall", stall_req, 0);
        chk("div_done_we", hilo_we, 1);
        cyc();
        op_valid = 1'b0;
        neg();
        chk("div_after_busy", busy, 0);
        chk("div_after_sign", div_sign, 0);

        // DIVU completes while stall_next held for 3 cycles
        cyc();
        op_valid = 1'b1; op_code = 3'd3; num1 = 32'd100; num2 = 32'd7;
        cyc();
        neg();
        chk("divu_sign", div_sign, 0);
        div_res_valid = 1'b1; div_result = {32'd2, 32'd14}; stall_next = 1'b1;
        exp_q.push_back({32'd2, 32'd14});
        cyc();
        div_res_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("divu_hold_we", hilo_we, 0);
            chk("divu_hold_busy", busy, 1);
            chk("divu_hold_opn", div_opn_valid, 0);
            cyc();
        end
        stall_next = 1'b0;
        neg();
        chk("divu_release_we", hilo_we, 1);
        cyc();
        op_valid = 1'b0;
        neg();
        chk("divu_idle", busy, 0);

        // DIV flushed on the 10th BUSY cycle
        cyc();
        op_valid = 1'b1; op_code = 3'd2; num1 = 32'd50; num2 = 32'd3;
        cyc();
        repeat (9) cyc();
        flush = 1'b1;
        neg();
        chk("flush_abort", div_abort, 1);
        chk("flush_we", hilo_we, 0);
        cyc();
        flush = 1'b0; op_valid = 1'b0;
        neg();
        chk("flush_busy", busy, 0);
        chk("flush_abort_end", div_abort, 0);
        chk("flush_stall", stall_req, 0);
        chk("flush_err", div_err, 0);
        cyc(); cyc();

        // DIVU by zero
        op_valid = 1'b1; op_code = 3'd3; num1 = 32'h1234; num2 = 32'd0;
        exp_q.push_back({32'h1234, 32'hFFFF_FFFF});
        neg();
        chk("dz_opn_valid", div_opn_valid, 0);
        chk("dz_we", hilo_we, 1);
        chk("dz_stall", stall_req, 0);
        cyc();
        op_valid = 1'b0;
        neg();
        chk("dz_busy", busy, 0);

        // Divider hangs: timeout on the 40th BUSY cycle
        cyc();
        op_valid = 1'b1; op_code = 3'd2; num1 = 32'd9; num2 = 32'd3;
        cyc();
        repeat (38) cyc();
        neg();
        chk("to_abort_39", div_abort, 0);
        cyc();
        neg();
        chk("to_abort_40", div_abort, 1);
        chk("to_err_pre", div_err, 0);
        exp_q.push_back(64'd0);
        cyc();
        neg();
        chk("to_err", div_err, 1);
        chk("to_abort_done", div_abort, 0);
        chk("to_we", hilo_we, 1);
        cyc();
        op_valid = 1'b0;
        neg();
        chk("to_busy", busy, 0);
        cyc(); cyc();
        neg();
        chk("to_err_sticky", div_err, 1);

        // Reset mid-divide
        cyc();
        op_valid = 1'b1; op_code = 3'd3; num1 = 32'd77; num2 = 32'd5;
        cyc(); cyc(); cyc();
        rst = 1'b1; op_valid = 1'b0;
        cyc();
        rst = 1'b0;
        neg();
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_err", div_err, 0);
        chk("rst_mid_we", hilo_we, 0);
        cyc(); cyc();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
